// File: rtl/branch_hazard_ctrl_if.sv
// Bundle between the ID stage and the branch hazard sequencer.
// Counter ports exist only when BRANCH_PERF_CNT_EN is defined.
interface branch_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic       i_ID_Branch;
  logic       i_ID_UsesRt;
  logic [4:0] i_Rs;
  logic [4:0] i_Rt;
  logic       i_IDEX_RegWrite;
  logic       i_IDEX_MemRead;
  logic [4:0] i_IDEX_RegisterRD;
  logic       i_EXMEM_RegWrite;
  logic       i_EXMEM_MemRead;
  logic [4:0] i_EXMEM_RegisterRD;
  logic       i_BranchTaken;
  logic       o_Stall;
  logic       o_Resolve;
  logic       o_PCSrc;
  logic       o_Flush_IFID;
  logic [1:0] o_dbg_state;
`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] o_BranchCnt;
  logic [CNT_W-1:0] o_TakenCnt;
  logic [CNT_W-1:0] o_StallCnt;
`endif

  modport master (
    output i_ID_Branch, i_ID_UsesRt, i_Rs, i_Rt,
    output i_IDEX_RegWrite, i_IDEX_MemRead, i_IDEX_RegisterRD,
    output i_EXMEM_RegWrite, i_EXMEM_MemRead, i_EXMEM_RegisterRD,
    output i_BranchTaken,
    input  o_Stall, o_Resolve, o_PCSrc, o_Flush_IFID, o_dbg_state
`ifdef BRANCH_PERF_CNT_EN
    , input o_BranchCnt, o_TakenCnt, o_StallCnt
`endif
  );

  modport slave (
    input  i_ID_Branch, i_ID_UsesRt, i_Rs, i_Rt,
    input  i_IDEX_RegWrite, i_IDEX_MemRead, i_IDEX_RegisterRD,
    input  i_EXMEM_RegWrite, i_EXMEM_MemRead, i_EXMEM_RegisterRD,
    input  i_BranchTaken,
    output o_Stall, o_Resolve, o_PCSrc, o_Flush_IFID, o_dbg_state
`ifdef BRANCH_PERF_CNT_EN
    , output o_BranchCnt, o_TakenCnt, o_StallCnt
`endif
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard sequencer: stalls until branch operands are forwardable, then resolves.
// Optional performance counters enabled by defining BRANCH_PERF_CNT_EN.
module branch_hazard_ctrl #(
  parameter int LOAD_STALLS = 2,
  parameter int ALU_STALLS  = 0,
  parameter int CNT_W       = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  branch_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STALL   = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  localparam logic [1:0] C_LOAD_IDEX  = 2'(LOAD_STALLS);
  localparam logic [1:0] C_LOAD_EXMEM = 2'(LOAD_STALLS - 1);
  localparam logic [1:0] C_ALU_IDEX   = 2'(ALU_STALLS);

  state_t     r_state;
  logic [1:0] r_cnt;

  logic       w_idex_match;
  logic       w_exmem_match;
  logic [1:0] w_n_idex;
  logic [1:0] w_n_exmem;
  logic [1:0] w_n;
  logic       w_start;
  logic       w_stall;
  logic       w_resolve;
  logic       w_pcsrc;

  // $0 is hardwired to zero, so a writer targeting it never blocks a branch.
  function automatic logic f_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  assign w_idex_match  = f_match(bus.i_IDEX_RegisterRD, bus.i_Rs, bus.i_Rt, bus.i_ID_UsesRt);
  assign w_exmem_match = f_match(bus.i_EXMEM_RegisterRD, bus.i_Rs, bus.i_Rt, bus.i_ID_UsesRt);

  always_comb begin
    w_n_idex = 2'd0;
    if (bus.i_IDEX_RegWrite && w_idex_match) begin
      w_n_idex = bus.i_IDEX_MemRead ? C_LOAD_IDEX : C_ALU_IDEX;
    end
  end

  always_comb begin
    w_n_exmem = 2'd0;
    if (bus.i_EXMEM_MemRead && bus.i_EXMEM_RegWrite && w_exmem_match) begin
      w_n_exmem = C_LOAD_EXMEM;
    end
  end

  assign w_n     = (w_n_idex > w_n_exmem) ? w_n_idex : w_n_exmem;
  assign w_start = (r_state == S_IDLE) && bus.i_ID_Branch;

  // Outputs are Mealy so a hazard-free branch resolves in the cycle it appears.
  assign w_stall   = !i_reset && ((w_start && (w_n != 2'd0)) || (r_state == S_STALL));
  assign w_resolve = !i_reset && ((w_start && (w_n == 2'd0)) || (r_state == S_RESOLVE));
  assign w_pcsrc   = w_resolve && bus.i_BranchTaken;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_ID_Branch && (w_n != 2'd0)) begin
            r_cnt   <= w_n - 2'd1;
            r_state <= (w_n > 2'd1) ? S_STALL : S_RESOLVE;
          end
        end
        S_STALL: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) begin
            r_state <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Stall      = w_stall;
  assign bus.o_Resolve    = w_resolve;
  assign bus.o_PCSrc      = w_pcsrc;
  assign bus.o_Flush_IFID = w_pcsrc;
  assign bus.o_dbg_state  = r_state;

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_resolve && (r_branch_cnt != '1)) r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_pcsrc && (r_taken_cnt != '1))    r_taken_cnt  <= r_taken_cnt + 1'b1;
      if (w_stall && (r_stall_cnt != '1))    r_stall_cnt  <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.o_BranchCnt = r_branch_cnt;
  assign bus.o_TakenCnt  = r_taken_cnt;
  assign bus.o_StallCnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: two instances (default and LOAD=3/ALU=1/CNT_W=2) share stimulus
// and are checked each cycle against a queue-based model of the stall/resolve schedule.
module tb_branch_hazard_ctrl;

  localparam int LS0 = 2, AS0 = 0, CW0 = 32;
  localparam int LS1 = 3, AS1 = 1, CW1 = 2;
  localparam logic [1:0] E_NONE = 2'd0, E_STALL = 2'd1, E_RES = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       br, urt, idrw, idmr, emrw, emmr, tk;
  logic [4:0] rs, rt, idrd, emrd;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];
  longint m_br[2], m_tk[2], m_st[2];

  always #5 clk = ~clk;

  branch_hazard_ctrl_if #(.CNT_W(CW0)) bus0 ();
  branch_hazard_ctrl_if #(.CNT_W(CW1)) bus1 ();

  assign bus0.i_ID_Branch = br;        assign bus1.i_ID_Branch = br;
  assign bus0.i_ID_UsesRt = urt;       assign bus1.i_ID_UsesRt = urt;
  assign bus0.i_Rs = rs;               assign bus1.i_Rs = rs;
  assign bus0.i_Rt = rt;               assign bus1.i_Rt = rt;
  assign bus0.i_IDEX_RegWrite = idrw;  assign bus1.i_IDEX_RegWrite = idrw;
  assign bus0.i_IDEX_MemRead = idmr;   assign bus1.i_IDEX_MemRead = idmr;
  assign bus0.i_IDEX_RegisterRD = idrd; assign bus1.i_IDEX_RegisterRD = idrd;
  assign bus0.i_EXMEM_RegWrite = emrw; assign bus1.i_EXMEM_RegWrite = emrw;
  assign bus0.i_EXMEM_MemRead = emmr;  assign bus1.i_EXMEM_MemRead = emmr;
  assign bus0.i_EXMEM_RegisterRD = emrd; assign bus1.i_EXMEM_RegisterRD = emrd;
  assign bus0.i_BranchTaken = tk;      assign bus1.i_BranchTaken = tk;

  branch_hazard_ctrl #(.LOAD_STALLS(LS0), .ALU_STALLS(AS0), .CNT_W(CW0)) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(bus0.slave));
  branch_hazard_ctrl #(.LOAD_STALLS(LS1), .ALU_STALLS(AS1), .CNT_W(CW1)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(bus1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reg_match(input logic [4:0] r);
    return (r != 5'd0) && ((r == rs) || (urt && (r == rt)));
  endfunction

  // Stall count demanded by the in-flight writers, worst source wins.
  function automatic int calc_n(input int ls, input int as);
    int n;
    n = 0;
    if (idrw && reg_match(idrd)) n = idmr ? ls : as;
    if (emmr && emrw && reg_match(emrd) && (ls - 1 > n)) n = ls - 1;
    return n;
  endfunction

  task automatic model_unit(input int u, output logic [1:0] code);
    int n;
    n = (u == 0) ? calc_n(LS0, AS0) : calc_n(LS1, AS1);
    code = E_NONE;
    if (rst) begin
      if (u == 0) exp_q0.delete(); else exp_q1.delete();
    end else if ((u == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0)) begin
      code = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    end else if (br) begin
      code = (n == 0) ? E_RES : E_STALL;
      for (int k = 1; k < n; k++) begin
        if (u == 0) exp_q0.push_back(E_STALL); else exp_q1.push_back(E_STALL);
      end
      if (n > 0) begin
        if (u == 0) exp_q0.push_back(E_RES); else exp_q1.push_back(E_RES);
      end
    end
  endtask

  task automatic check_unit(input int u);
    logic [1:0] code;
    logic e_st, e_rs, e_pc;
    logic [31:0] o_st, o_rs, o_pc, o_fl;
    longint mx;
    model_unit(u, code);
    e_st = (code == E_STALL);
    e_rs = (code == E_RES);
    e_pc = e_rs && tk;
    o_st = (u == 0) ? 32'(bus0.o_Stall) : 32'(bus1.o_Stall);
    o_rs = (u == 0) ? 32'(bus0.o_Resolve) : 32'(bus1.o_Resolve);
    o_pc = (u == 0) ? 32'(bus0.o_PCSrc) : 32'(bus1.o_PCSrc);
    o_fl = (u == 0) ? 32'(bus0.o_Flush_IFID) : 32'(bus1.o_Flush_IFID);
    check($sformatf("u%0d_stall", u), o_st, 32'(e_st));
    check($sformatf("u%0d_resolve", u), o_rs, 32'(e_rs));
    check($sformatf("u%0d_pcsrc", u), o_pc, 32'(e_pc));
    check($sformatf("u%0d_flush", u), o_fl, 32'(e_pc));
`ifdef BRANCH_PERF_CNT_EN
    check($sformatf("u%0d_branch_cnt", u),
          (u == 0) ? 32'(bus0.o_BranchCnt) : 32'(bus1.o_BranchCnt), 32'(m_br[u]));
    check($sformatf("u%0d_taken_cnt", u),
          (u == 0) ? 32'(bus0.o_TakenCnt) : 32'(bus1.o_TakenCnt), 32'(m_tk[u]));
    check($sformatf("u%0d_stall_cnt", u),
          (u == 0) ? 32'(bus0.o_StallCnt) : 32'(bus1.o_StallCnt), 32'(m_st[u]));
`endif
    mx = (64'd1 << ((u == 0) ? CW0 : CW1)) - 1;
    if (rst) begin
      m_br[u] = 0; m_tk[u] = 0; m_st[u] = 0;
    end else begin
      if (e_rs && m_br[u] < mx) m_br[u]++;
      if (e_pc && m_tk[u] < mx) m_tk[u]++;
      if (e_st && m_st[u] < mx) m_st[u]++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_unit(0);
    check_unit(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic u, input logic [4:0] s, input logic [4:0] t,
                       input logic irw, input logic imr, input logic [4:0] ird,
                       input logic erw, input logic emr, input logic [4:0] erd, input logic k);
    br = b; urt = u; rs = s; rt = t;
    idrw = irw; idmr = imr; idrd = ird;
    emrw = erw; emmr = emr; emrd = erd; tk = k;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin m_br[u] = 0; m_tk[u] = 0; m_st[u] = 0; end
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    // beq 3,4 no writers, taken
    drive(1, 1, 3, 4, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // lw $5 in ID/EX, beq Rs=5, not taken; branch drops while stalled
    drive(1, 1, 5, 0, 1, 1, 5, 0, 0, 0, 0);
    idle(4);
    // lw $6 in EX/MEM, bne Rt=6 with and without Rt usage
    drive(1, 1, 1, 6, 0, 0, 0, 1, 1, 6, 1);
    idle(4);
    drive(1, 0, 1, 6, 0, 0, 0, 1, 1, 6, 1);
    idle(4);
    // add $7 in ID/EX, then destination $0 cases
    drive(1, 1, 7, 2, 1, 0, 7, 0, 0, 0, 1);
    idle(3);
    drive(1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 1);
    idle(3);
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    // reset on first stall cycle, then reset in the middle of a stall
    rst = 1'b1;
    drive(1, 1, 5, 0, 1, 1, 5, 0, 0, 0, 1);
    rst = 1'b0;
    idle(3);
    drive(1, 1, 5, 0, 1, 1, 5, 0, 0, 0, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(4);
    // back-to-back hazard-free branches
    drive(1, 1, 3, 4, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 3, 4, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 3, 4, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // randomized traffic with small register numbers to provoke matches
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
